// File: rtl/commit_trace_pkg.sv
// Shared widths, destination-type codes and the stored trace record layout.
package commit_trace_pkg;

    localparam int unsigned XLEN      = 64;
    localparam int unsigned VLEN      = 256;
    localparam int unsigned ADDR_BITS = 40;
    localparam int unsigned LREG_SZ   = 5;
    localparam int unsigned VEC_W     = VLEN * 8;
    localparam int unsigned VMASK_W   = 8;
    localparam int unsigned INST_W    = 32;
    localparam int unsigned TAG_W     = 64;
    localparam int unsigned RTYPE_W   = 3;
    localparam int unsigned SEQ_W     = 64;
    localparam int unsigned DROP_W    = 32;

    localparam logic [RTYPE_W-1:0] RT_FIX = 3'd0;
    localparam logic [RTYPE_W-1:0] RT_FLT = 3'd1;
    localparam logic [RTYPE_W-1:0] RT_VEC = 3'd2;
    localparam logic [RTYPE_W-1:0] RT_X   = 3'd3;

    typedef struct packed {
        logic [ADDR_BITS-1:0] pc;
        logic [INST_W-1:0]    inst;
        logic [LREG_SZ-1:0]   ldst;
        logic [RTYPE_W-1:0]   dst_rtype;
        logic [TAG_W-1:0]     tag;
        logic [XLEN-1:0]      wdata;
        logic [VEC_W-1:0]     vec_wdata;
        logic [VMASK_W-1:0]   vec_wmask;
        logic [SEQ_W-1:0]     seq;
    } trace_rec_t;

endpackage

// File: rtl/commit_trace_queue_if.sv
// Retire-port bundle in, head-record/valid-ready stream out, plus status.
interface commit_trace_queue_if #(
    parameter int unsigned RETIRE_WIDTH = 3
);
    import commit_trace_pkg::*;

    logic [RETIRE_WIDTH-1:0]           commit_arch_valids;
    logic [RETIRE_WIDTH*LREG_SZ-1:0]   commit_ldst;
    logic [RETIRE_WIDTH*RTYPE_W-1:0]   commit_dst_rtype;
    logic [RETIRE_WIDTH*ADDR_BITS-1:0] commit_debug_pc;
    logic [RETIRE_WIDTH*INST_W-1:0]    commit_debug_inst;
    logic [RETIRE_WIDTH*TAG_W-1:0]     commit_debug_tag;
    logic [RETIRE_WIDTH*XLEN-1:0]      commit_debug_wdata;
    logic [RETIRE_WIDTH*VEC_W-1:0]     commit_debug_vec_wdata;
    logic [RETIRE_WIDTH*VMASK_W-1:0]   commit_debug_vec_wmask;

    logic                 out_valid;
    logic                 out_ready;
    logic [LREG_SZ-1:0]   out_ldst;
    logic [RTYPE_W-1:0]   out_dst_rtype;
    logic [ADDR_BITS-1:0] out_pc;
    logic [INST_W-1:0]    out_inst;
    logic [TAG_W-1:0]     out_tag;
    logic [XLEN-1:0]      out_wdata;
    logic [VEC_W-1:0]     out_vec_wdata;
    logic [VMASK_W-1:0]   out_vec_wmask;
    logic [SEQ_W-1:0]     out_seq;
    logic                 almost_full;
    logic                 overflow;
    logic [DROP_W-1:0]    drop_count;

    // Core/harness side: drives commits and ready, observes the stream.
    modport master (
        output commit_arch_valids, commit_ldst, commit_dst_rtype, commit_debug_pc,
               commit_debug_inst, commit_debug_tag, commit_debug_wdata,
               commit_debug_vec_wdata, commit_debug_vec_wmask, out_ready,
        input  out_valid, out_ldst, out_dst_rtype, out_pc, out_inst, out_tag,
               out_wdata, out_vec_wdata, out_vec_wmask, out_seq,
               almost_full, overflow, drop_count
    );

    // Queue side.
    modport slave (
        input  commit_arch_valids, commit_ldst, commit_dst_rtype, commit_debug_pc,
               commit_debug_inst, commit_debug_tag, commit_debug_wdata,
               commit_debug_vec_wdata, commit_debug_vec_wmask, out_ready,
        output out_valid, out_ldst, out_dst_rtype, out_pc, out_inst, out_tag,
               out_wdata, out_vec_wdata, out_vec_wmask, out_seq,
               almost_full, overflow, drop_count
    );

endinterface

// File: rtl/commit_lane_compactor.sv
// Exclusive prefix sum of lane valids: per-lane slot offset and total count.
module commit_lane_compactor #(
    parameter int unsigned RETIRE_WIDTH = 3,
    parameter int unsigned OFF_W        = $clog2(RETIRE_WIDTH + 1)
) (
    input  logic [RETIRE_WIDTH-1:0]            valids_i,
    output logic [RETIRE_WIDTH-1:0][OFF_W-1:0] offset_c_o,
    output logic [OFF_W-1:0]                   n_c_o
);

    logic [OFF_W-1:0] acc;

    // Running count of older valid lanes gives each lane its compacted index.
    always_comb begin
        acc        = '0;
        offset_c_o = '0;
        for (int i = 0; i < int'(RETIRE_WIDTH); i++) begin
            offset_c_o[i] = acc;
            acc           = acc + OFF_W'(valids_i[i]);
        end
        n_c_o = acc;
    end

endmodule

// File: rtl/commit_trace_queue.sv
// Circular commit-trace buffer: compacts retire lanes, tags sequence numbers,
// drains one record per cycle, and accounts for whole-cycle drops.
module commit_trace_queue
    import commit_trace_pkg::*;
#(
    parameter int unsigned RETIRE_WIDTH = 3,
    parameter int unsigned DEPTH        = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    commit_trace_queue_if.slave  bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OFF_W = $clog2(RETIRE_WIDTH + 1);

    trace_rec_t mem_q [DEPTH];

    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              overflow_q, overflow_d;
    logic              af_q, af_d;

    logic [RETIRE_WIDTH-1:0][OFF_W-1:0] lane_off;
    logic [OFF_W-1:0]                   n;
    logic [CNT_W-1:0]                   free;
    logic                               accept, deq;
    logic [DROP_W:0]                    drop_sum;
    trace_rec_t                         lane_rec [RETIRE_WIDTH];
    trace_rec_t                         head_rec;

    commit_lane_compactor #(
        .RETIRE_WIDTH (RETIRE_WIDTH),
        .OFF_W        (OFF_W)
    ) u_compactor (
        .valids_i   (bus.commit_arch_valids),
        .offset_c_o (lane_off),
        .n_c_o      (n)
    );

    // Unpack each retire lane into a record tagged with its sequence number.
    always_comb begin
        for (int i = 0; i < int'(RETIRE_WIDTH); i++) begin
            lane_rec[i].pc        = bus.commit_debug_pc[i*ADDR_BITS +: ADDR_BITS];
            lane_rec[i].inst      = bus.commit_debug_inst[i*INST_W +: INST_W];
            lane_rec[i].ldst      = bus.commit_ldst[i*LREG_SZ +: LREG_SZ];
            lane_rec[i].dst_rtype = bus.commit_dst_rtype[i*RTYPE_W +: RTYPE_W];
            lane_rec[i].tag       = bus.commit_debug_tag[i*TAG_W +: TAG_W];
            lane_rec[i].wdata     = bus.commit_debug_wdata[i*XLEN +: XLEN];
            lane_rec[i].vec_wdata = bus.commit_debug_vec_wdata[i*VEC_W +: VEC_W];
            lane_rec[i].vec_wmask = bus.commit_debug_vec_wmask[i*VMASK_W +: VMASK_W];
            lane_rec[i].seq       = seq_q + SEQ_W'(lane_off[i]);
        end
    end

    // Next-state: all-or-nothing accept against registered free space.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        seq_d      = seq_q;
        drop_d     = drop_q;
        overflow_d = overflow_q;
        drop_sum   = '0;

        free   = CNT_W'(DEPTH) - count_q;
        accept = (CNT_W'(n) <= free);
        deq    = (count_q != '0) && bus.out_ready;

        if (accept) begin
            tail_d = tail_q + PTR_W'(n);
            seq_d  = seq_q + SEQ_W'(n);
        end else begin
            overflow_d = 1'b1;
            drop_sum   = {1'b0, drop_q} + (DROP_W + 1)'(n);
            drop_d     = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
        end

        if (deq) begin
            head_d = head_q + PTR_W'(1);
        end

        count_d = count_q + (accept ? CNT_W'(n) : CNT_W'(0)) - CNT_W'(deq);
        af_d    = (CNT_W'(DEPTH) - count_d) < CNT_W'(RETIRE_WIDTH);
    end

    // Control state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            seq_q      <= '0;
            drop_q     <= '0;
            overflow_q <= 1'b0;
            af_q       <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            seq_q      <= seq_d;
            drop_q     <= drop_d;
            overflow_q <= overflow_d;
            af_q       <= af_d;
        end
    end

    // Record storage; contents are only meaningful between head and tail.
    always_ff @(posedge clock) begin
        if (!reset && accept) begin
            for (int i = 0; i < int'(RETIRE_WIDTH); i++) begin
                if (bus.commit_arch_valids[i]) begin
                    mem_q[tail_q + PTR_W'(lane_off[i])] <= lane_rec[i];
                end
            end
        end
    end

    // Head record, forced to zero while the queue is empty.
    always_comb begin
        head_rec = '0;
        if (count_q != '0) begin
            head_rec = mem_q[head_q];
        end
    end

    assign bus.out_valid     = (count_q != '0);
    assign bus.out_ldst      = head_rec.ldst;
    assign bus.out_dst_rtype = head_rec.dst_rtype;
    assign bus.out_pc        = head_rec.pc;
    assign bus.out_inst      = head_rec.inst;
    assign bus.out_tag       = head_rec.tag;
    assign bus.out_wdata     = head_rec.wdata;
    assign bus.out_vec_wdata = head_rec.vec_wdata;
    assign bus.out_vec_wmask = head_rec.vec_wmask;
    assign bus.out_seq       = head_rec.seq;
    assign bus.almost_full   = af_q;
    assign bus.overflow      = overflow_q;
    assign bus.drop_count    = drop_q;

endmodule

// File: tb/tb_commit_trace_queue.sv
// Scoreboard bench for commit_trace_queue (RETIRE_WIDTH=3, DEPTH=16).
module tb_commit_trace_queue;

    localparam int RW  = 3;
    localparam int DEP = 16;

    typedef struct {
        logic [39:0] pc;
        logic [63:0] wdata;
        logic [4:0]  ldst;
        logic [63:0] seq;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    commit_trace_queue_if #(.RETIRE_WIDTH(RW)) bus ();

    commit_trace_queue #(.RETIRE_WIDTH(RW), .DEPTH(DEP)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        sb [$];
    int          mdl_count;
    logic [63:0] mdl_seq;
    logic [31:0] mdl_drop;
    logic        mdl_ovf;
    logic [63:0] last_seq;
    logic [39:0] lane_pc [RW];
    logic [63:0] lane_wd [RW];
    logic [4:0]  lane_ld [RW];

    task automatic set_lanes(input logic [39:0] base);
        for (int i = 0; i < RW; i++) begin
            lane_pc[i] = base + 40'(i * 4);
            lane_wd[i] = {24'h0, base} ^ 64'(i + 1);
            lane_ld[i] = base[6:2] + 5'(i);
        end
    endtask

    task automatic do_reset(input logic [2:0] v);
        rst = 1'b1;
        set_lanes(40'h0dead_0000);
        bus.commit_arch_valids = v;
        bus.out_ready = 1'b1;
        for (int i = 0; i < RW; i++) begin
            bus.commit_debug_pc[i*40 +: 40] = lane_pc[i];
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.commit_arch_valids = '0;
        sb.delete();
        mdl_count = 0;
        mdl_seq   = '0;
        mdl_drop  = '0;
        mdl_ovf   = 1'b0;
    endtask

    // One clock of stimulus; pops and compares the scoreboard on handshake.
    task automatic drive_cycle(input logic [2:0] v, input logic rdy, output bit acc);
        exp_t e;
        int   n;
        int   k;
        bit   deq;
        bus.commit_arch_valids = v;
        bus.out_ready = rdy;
        for (int i = 0; i < RW; i++) begin
            bus.commit_debug_pc[i*40 +: 40]    = lane_pc[i];
            bus.commit_debug_wdata[i*64 +: 64] = lane_wd[i];
            bus.commit_ldst[i*5 +: 5]          = lane_ld[i];
        end
        n_checks++;
        if (bus.out_valid !== (mdl_count != 0)) begin
            n_fail++;
            $display("FAIL out_valid: got %b want %b", bus.out_valid, mdl_count != 0);
        end
        deq = (mdl_count != 0) && rdy;
        if (deq) begin
            e = sb.pop_front();
            last_seq = e.seq;
            n_checks++;
            if (bus.out_pc !== e.pc || bus.out_seq !== e.seq ||
                bus.out_wdata !== e.wdata || bus.out_ldst !== e.ldst) begin
                n_fail++;
                $display("FAIL head_rec: got pc=%h seq=%0d wd=%h ld=%0d want pc=%h seq=%0d wd=%h ld=%0d",
                         bus.out_pc, bus.out_seq, bus.out_wdata, bus.out_ldst,
                         e.pc, e.seq, e.wdata, e.ldst);
            end
        end
        n   = $countones(v);
        acc = (n <= DEP - mdl_count);
        if (acc) begin
            k = 0;
            for (int i = 0; i < RW; i++) begin
                if (v[i]) begin
                    e.pc = lane_pc[i]; e.wdata = lane_wd[i]; e.ldst = lane_ld[i];
                    e.seq = mdl_seq + 64'(k);
                    sb.push_back(e);
                    k++;
                end
            end
            mdl_seq = mdl_seq + 64'(n);
        end else begin
            mdl_ovf  = 1'b1;
            mdl_drop = mdl_drop + 32'(n);
        end
        mdl_count = mdl_count + (acc ? n : 0) - (deq ? 1 : 0);
        @(posedge clk); #1;
        n_checks++;
        if (bus.almost_full !== ((DEP - mdl_count) < RW)) begin
            n_fail++;
            $display("FAIL almost_full: got %b want %b", bus.almost_full, (DEP - mdl_count) < RW);
        end
        n_checks++;
        if (bus.overflow !== mdl_ovf || bus.drop_count !== mdl_drop) begin
            n_fail++;
            $display("FAIL drop_state: got ovf=%b drop=%0d want ovf=%b drop=%0d",
                     bus.overflow, bus.drop_count, mdl_ovf, mdl_drop);
        end
    endtask

    task automatic drain(input int budget);
        bit acc;
        int cyc = 0;
        while (mdl_count != 0 && cyc < budget) begin
            drive_cycle(3'b000, 1'b1, acc);
            cyc++;
        end
        n_checks++;
        if (bus.out_valid !== 1'b0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_empty: got out_valid=%b sb=%0d want 0 0", bus.out_valid, sb.size());
        end
    endtask

    task automatic test_reset();
        do_reset(3'b000);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.almost_full !== 1'b0 || bus.overflow !== 1'b0 ||
            bus.drop_count !== 32'd0 || bus.out_pc !== 40'd0 || bus.out_seq !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b af=%b ovf=%b drop=%0d pc=%h seq=%0d want all 0",
                     bus.out_valid, bus.almost_full, bus.overflow, bus.drop_count,
                     bus.out_pc, bus.out_seq);
        end
    endtask

    task automatic test_single();
        bit acc;
        do_reset(3'b000);
        set_lanes(40'h00_8000_0000);
        lane_wd[0] = 64'h1234;
        drive_cycle(3'b001, 1'b1, acc);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 40'h00_8000_0000 ||
            bus.out_seq !== 64'd0 || bus.out_wdata !== 64'h1234) begin
            n_fail++;
            $display("FAIL single_head: got v=%b pc=%h seq=%0d wd=%h want 1 8000_0000 0 1234",
                     bus.out_valid, bus.out_pc, bus.out_seq, bus.out_wdata);
        end
        drive_cycle(3'b000, 1'b1, acc);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_empty: got out_valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_sparse();
        bit acc;
        do_reset(3'b000);
        set_lanes(40'h00_4000_1000);
        drive_cycle(3'b101, 1'b1, acc);
        drive_cycle(3'b000, 1'b1, acc);
        n_checks++;
        if (bus.out_pc !== 40'h00_4000_1008 || bus.out_seq !== 64'd1) begin
            n_fail++;
            $display("FAIL sparse_second: got pc=%h seq=%0d want 4000_1008 1", bus.out_pc, bus.out_seq);
        end
        drain(8);
    endtask

    task automatic test_overflow();
        bit acc;
        do_reset(3'b000);
        for (int c = 0; c < 5; c++) begin
            set_lanes(40'h00_2000_0000 + 40'(c * 16));
            drive_cycle(3'b111, 1'b0, acc);
        end
        n_checks++;
        if (bus.almost_full !== 1'b1 || bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL fill15: got af=%b ovf=%b want 1 0", bus.almost_full, bus.overflow);
        end
        set_lanes(40'h00_2000_0100);
        drive_cycle(3'b111, 1'b0, acc);
        n_checks++;
        if (bus.overflow !== 1'b1 || bus.drop_count !== 32'd3 || bus.out_pc !== 40'h00_2000_0000) begin
            n_fail++;
            $display("FAIL reject3: got ovf=%b drop=%0d head=%h want 1 3 2000_0000",
                     bus.overflow, bus.drop_count, bus.out_pc);
        end
        set_lanes(40'h00_2000_0200);
        drive_cycle(3'b001, 1'b0, acc);
    endtask

    task automatic test_full_deq();
        bit acc;
        set_lanes(40'h00_2000_0300);
        drive_cycle(3'b001, 1'b1, acc);
        n_checks++;
        if (bus.drop_count !== 32'd4 || bus.out_valid !== 1'b1 || bus.out_seq !== 64'd1) begin
            n_fail++;
            $display("FAIL full_deq: got drop=%0d v=%b seq=%0d want 4 1 1",
                     bus.drop_count, bus.out_valid, bus.out_seq);
        end
        drain(40);
        n_checks++;
        if (last_seq !== 64'd15) begin
            n_fail++;
            $display("FAIL full_last_seq: got %0d want 15", last_seq);
        end
    endtask

    task automatic test_stream();
        bit          acc;
        int          accepted = 0;
        int          cyc = 0;
        logic [2:0]  v;
        logic [39:0] pcb = 40'h00_1000_0000;
        do_reset(3'b000);
        while (accepted < 40 && cyc < 2000) begin
            v = 3'($urandom_range(0, 7));
            if (40 - accepted < 3) v = 3'b001;
            set_lanes(pcb);
            pcb = pcb + 40'h100;
            drive_cycle(v, 1'($urandom_range(0, 1)), acc);
            if (acc) accepted += $countones(v);
            cyc++;
        end
        n_checks++;
        if (accepted != 40) begin
            n_fail++;
            $display("FAIL stream_budget: got %0d accepted want 40", accepted);
        end
        cyc = 0;
        while (mdl_count != 0 && cyc < 2000) begin
            drive_cycle(3'b000, 1'($urandom_range(0, 1)), acc);
            cyc++;
        end
        n_checks++;
        if (last_seq !== 64'd39 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_end: got last_seq=%0d v=%b want 39 0", last_seq, bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        bit acc;
        do_reset(3'b000);
        for (int c = 0; c < 5; c++) begin
            set_lanes(40'h00_3000_0000 + 40'(c * 16));
            drive_cycle(3'b111, 1'b0, acc);
        end
        drive_cycle(3'b001, 1'b0, acc);
        drive_cycle(3'b111, 1'b0, acc);
        for (int c = 0; c < 9; c++) drive_cycle(3'b000, 1'b1, acc);
        n_checks++;
        if (bus.overflow !== 1'b1 || bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: got ovf=%b v=%b want 1 1", bus.overflow, bus.out_valid);
        end
        do_reset(3'b111);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.overflow !== 1'b0 || bus.drop_count !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got v=%b ovf=%b drop=%0d want 0 0 0",
                     bus.out_valid, bus.overflow, bus.drop_count);
        end
        set_lanes(40'h00_3300_0000);
        drive_cycle(3'b001, 1'b1, acc);
        n_checks++;
        if (bus.out_seq !== 64'd0 || bus.out_pc !== 40'h00_3300_0000) begin
            n_fail++;
            $display("FAIL post_reset_seq: got seq=%0d pc=%h want 0 3300_0000", bus.out_seq, bus.out_pc);
        end
        drain(8);
    endtask

    initial begin
        bus.commit_arch_valids     = '0;
        bus.commit_ldst            = '0;
        bus.commit_dst_rtype       = '0;
        bus.commit_debug_pc        = '0;
        bus.commit_debug_inst      = '0;
        bus.commit_debug_tag       = '0;
        bus.commit_debug_wdata     = '0;
        bus.commit_debug_vec_wdata = '0;
        bus.commit_debug_vec_wmask = '0;
        bus.out_ready              = 1'b0;
        last_seq                   = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_sparse();
        test_overflow();
        test_full_deq();
        test_stream();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
